// File: rtl/instr_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
//   XLEN         : width of fetch addresses and instruction words
//   IF_NOP_WORD  : instruction presented at IF/ID when no valid entry exists
//   word_t       : one address or instruction word
//   ifid_t       : IF/ID boundary bundle {instr, pc, valid}
package instr_fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t IF_NOP_WORD = 32'h0000_0000;

  typedef struct packed {
    word_t instr;
    word_t pc;
    logic  valid;
  } ifid_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Skid FIFO that holds fetched {instruction, pc} pairs in front of decode.
//   Clk, Reset : clock, synchronous active-high reset
//   clear_i    : drop all entries (redirect); overrides push and pop
//   push_i     : write {instr_i, pc_i} at the write pointer
//   pop_i      : consume the head entry; ignored when empty
//   instr_i    : instruction word to store
//   pc_i       : address of instr_i
//   head_o     : head entry, or {NOP_WORD, 0, 0} when empty
//   count_o    : number of stored entries (0..DEPTH)
module fetch_skid_fifo
  import instr_fetch_stage_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter word_t       NOP_WORD = IF_NOP_WORD,
  localparam int unsigned PTR_W   = $clog2(DEPTH),
  localparam int unsigned CNT_W   = PTR_W + 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  word_t            instr_i,
  input  word_t            pc_i,
  output ifid_t            head_o,
  output logic [CNT_W-1:0] count_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             pop_eff;

  word_t instr_mem_q [DEPTH];
  word_t pc_mem_q    [DEPTH];

  assign pop_eff = pop_i & (count_q != '0);

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer increments wrap naturally.
      if (push_i)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_eff) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_eff);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; count gates every read, so stale contents are never presented.
  always_ff @(posedge Clk) begin
    if (push_i && !clear_i) begin
      instr_mem_q[wr_ptr_q] <= instr_i;
      pc_mem_q[wr_ptr_q]    <= pc_i;
    end
  end

  always_comb begin
    head_o.valid = (count_q != '0);
    head_o.instr = head_o.valid ? instr_mem_q[rd_ptr_q] : NOP_WORD;
    head_o.pc    = head_o.valid ? pc_mem_q[rd_ptr_q]    : '0;
  end

  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: issues PC to a 1-cycle synchronous BRAM, tracks the
// single in-flight read and queues returned words in a skid FIFO for decode.
//   Clk, Reset  : clock, synchronous active-high reset
//   PC          : current fetch address
//   ID_stall    : decode cannot accept the head this cycle
//   Flush       : redirect; PC already holds the target
//   imem_addr   : BRAM read address (PC, combinational)
//   imem_en     : BRAM read enable / issue strobe
//   imem_rdata  : BRAM data, valid the cycle after issue
//   IF_stall    : PC register must hold
//   IFID_instr  : instruction at FIFO head (NOP_WORD when invalid)
//   IFID_pc     : address of IFID_instr (0 when invalid)
//   IFID_valid  : head entry valid
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter word_t       NOP_WORD = IF_NOP_WORD
) (
  input  logic  Clk,
  input  logic  Reset,
  input  word_t PC,
  input  logic  ID_stall,
  input  logic  Flush,
  output word_t imem_addr,
  output logic  imem_en,
  input  word_t imem_rdata,
  output logic  IF_stall,
  output word_t IFID_instr,
  output word_t IFID_pc,
  output logic  IFID_valid
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic             req_valid_q, req_valid_d;
  word_t            req_pc_q,    req_pc_d;
  logic [CNT_W-1:0] count;
  logic [SUM_W-1:0] occupancy;
  logic             pop;
  logic             push;
  logic             issue_ok;
  ifid_t            head;

  assign pop = head.valid & ~ID_stall;

  // Entries held plus the read in flight, minus what leaves this cycle.
  // A pop implies count >= 1, so the subtraction cannot underflow.
  assign occupancy = SUM_W'(count) + SUM_W'(req_valid_q) - SUM_W'(pop);
  assign issue_ok  = occupancy < SUM_W'(DEPTH);

  // A redirect always issues: the flush empties the FIFO and kills the in-flight read.
  assign imem_en   = ~Reset & (issue_ok | Flush);
  assign IF_stall  = ~imem_en;
  assign imem_addr = PC;

  assign req_valid_d = imem_en;
  assign req_pc_d    = imem_en ? PC : req_pc_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      req_valid_q <= 1'b0;
      req_pc_q    <= '0;
    end else begin
      req_valid_q <= req_valid_d;
      req_pc_q    <= req_pc_d;
    end
  end

  // Data returning during a flush belongs to the abandoned path.
  assign push = req_valid_q & ~Flush;

  fetch_skid_fifo #(
    .DEPTH    (DEPTH),
    .NOP_WORD (NOP_WORD)
  ) u_fifo (
    .Clk     (Clk),
    .Reset   (Reset),
    .clear_i (Flush),
    .push_i  (push),
    .pop_i   (pop),
    .instr_i (imem_rdata),
    .pc_i    (req_pc_q),
    .head_o  (head),
    .count_o (count)
  );

  assign IFID_instr = head.instr;
  assign IFID_pc    = head.pc;
  assign IFID_valid = head.valid;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: BRAM model returns addr+0x1000,
// issued PCs go into a scoreboard queue and are compared on every pop.
module tb_instr_fetch_stage;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] DATA_OFS = 32'h0000_1000;

  logic        Clk;
  logic        Reset;
  logic [31:0] PC;
  logic        ID_stall;
  logic        Flush;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;
  logic        IF_stall;
  logic [31:0] IFID_instr;
  logic [31:0] IFID_pc;
  logic        IFID_valid;

  int checks;
  int errors;
  int pops;

  logic [31:0] exp_q [$];

  // Values sampled at the negedge of the last driven cycle.
  logic        last_valid;
  logic [31:0] last_pc;
  logic [31:0] last_instr;
  logic        last_ifstall;
  logic        last_en;
  logic [31:0] last_addr;

  instr_fetch_stage #(.DEPTH(DEPTH), .NOP_WORD(32'h0000_0000)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .PC         (PC),
    .ID_stall   (ID_stall),
    .Flush      (Flush),
    .imem_addr  (imem_addr),
    .imem_en    (imem_en),
    .imem_rdata (imem_rdata),
    .IF_stall   (IF_stall),
    .IFID_instr (IFID_instr),
    .IFID_pc    (IFID_pc),
    .IFID_valid (IFID_valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // 1-cycle synchronous BRAM.
  always @(posedge Clk) begin
    if (imem_en) imem_rdata <= imem_addr + DATA_OFS;
  end

  // Overflow monitor: a push into a full FIFO without a pop or clear.
  always @(negedge Clk) begin
    if (!Reset && dut.u_fifo.push_i && !dut.u_fifo.pop_i && !dut.u_fifo.clear_i &&
        dut.u_fifo.count_q == 2'(DEPTH)) begin
      errors++;
      $display("FAIL overflow: push at count=%0d required no push when full", dut.u_fifo.count_q);
    end
  end

  task automatic apply_reset();
    Reset    = 1'b1;
    Flush    = 1'b0;
    ID_stall = 1'b0;
    PC       = 32'h0;
    repeat (2) begin
      @(posedge Clk);
      #1;
    end
    exp_q.delete();
    Reset = 1'b0;
    PC    = 32'h0;
  endtask

  // Drive one cycle, check the scoreboard at negedge, advance PC if issued.
  task automatic drive_cycle(input logic stall, input logic flush, input logic [31:0] target);
    logic [31:0] exp_pc;
    ID_stall = stall;
    Flush    = flush;
    if (flush) PC = target;
    @(negedge Clk);
    last_valid   = IFID_valid;
    last_pc      = IFID_pc;
    last_instr   = IFID_instr;
    last_ifstall = IF_stall;
    last_en      = imem_en;
    last_addr    = imem_addr;
    if (flush) begin
      exp_q.delete();
    end else if (IFID_valid && !stall) begin
      checks++;
      pops++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got pc=%h instr=%h, required no valid entry", IFID_pc, IFID_instr);
      end else begin
        exp_pc = exp_q.pop_front();
        if (IFID_pc !== exp_pc || IFID_instr !== exp_pc + DATA_OFS) begin
          errors++;
          $display("FAIL pop_order: got pc=%h instr=%h, required pc=%h instr=%h",
                   IFID_pc, IFID_instr, exp_pc, exp_pc + DATA_OFS);
        end
      end
    end else if (!IFID_valid) begin
      checks++;
      if (IFID_pc !== 32'h0 || IFID_instr !== 32'h0) begin
        errors++;
        $display("FAIL empty_head: got pc=%h instr=%h, required 0/0", IFID_pc, IFID_instr);
      end
    end
    if (imem_en) begin
      checks++;
      if (imem_addr !== PC) begin
        errors++;
        $display("FAIL imem_addr: got %h, required %h", imem_addr, PC);
      end
      exp_q.push_back(PC);
    end
    @(posedge Clk);
    #1;
    if (last_en) PC = PC + 32'h4;
  endtask

  task automatic test_reset();
    apply_reset();
    repeat (2) drive_cycle(1'b0, 1'b0, 32'h0);
    repeat (3) drive_cycle(1'b1, 1'b0, 32'h0);
    Reset = 1'b1;
    @(negedge Clk);
    checks++;
    if (imem_en !== 1'b0 || IF_stall !== 1'b1) begin
      errors++;
      $display("FAIL reset_issue: got en=%b if_stall=%b, required 0/1", imem_en, IF_stall);
    end
    @(posedge Clk);
    #1;
    @(negedge Clk);
    checks++;
    if (IFID_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b, required 0", IFID_valid);
    end
    @(posedge Clk);
    #1;
    exp_q.delete();
    Reset = 1'b0;
    PC    = 32'h0;
    drive_cycle(1'b0, 1'b0, 32'h0);
    checks++;
    if (last_valid !== 1'b0 || last_instr !== 32'h0 || last_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_release_head: got v=%b instr=%h pc=%h, required 0/0/0",
               last_valid, last_instr, last_pc);
    end
    checks++;
    if (last_en !== 1'b1 || last_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_first_issue: got en=%b addr=%h, required 1/0", last_en, last_addr);
    end
  endtask

  task automatic test_stream();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, 1'b0, 32'h0);
      checks++;
      if (last_ifstall !== 1'b0) begin
        errors++;
        $display("FAIL stream_if_stall c%0d: got %b, required 0", i, last_ifstall);
      end
      if (i < 2) begin
        checks++;
        if (last_valid !== 1'b0) begin
          errors++;
          $display("FAIL stream_latency c%0d: got valid=%b, required 0", i, last_valid);
        end
      end else begin
        checks++;
        if (last_valid !== 1'b1 || last_pc !== 32'(4 * (i - 2))) begin
          errors++;
          $display("FAIL stream_head c%0d: got v=%b pc=%h, required 1/%h",
                   i, last_valid, last_pc, 32'(4 * (i - 2)));
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] frozen;
    apply_reset();
    repeat (5) drive_cycle(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, 1'b0, 32'h0);
      if (i == 0) frozen = last_pc;
      checks++;
      if (last_ifstall !== 1'b1 || last_pc !== frozen) begin
        errors++;
        $display("FAIL stall_hold c%0d: got if_stall=%b pc=%h, required 1/%h",
                 i, last_ifstall, last_pc, frozen);
      end
    end
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b0, 1'b0, 32'h0);
      checks++;
      if (last_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_release_gap c%0d: got valid=%b, required 1", i, last_valid);
      end
    end
  endtask

  task automatic test_flush();
    apply_reset();
    repeat (5) drive_cycle(1'b0, 1'b0, 32'h0);
    drive_cycle(1'b0, 1'b1, 32'h40);
    checks++;
    if (last_en !== 1'b1 || last_addr !== 32'h40) begin
      errors++;
      $display("FAIL flush_issue: got en=%b addr=%h, required 1/00000040", last_en, last_addr);
    end
    drive_cycle(1'b0, 1'b0, 32'h0);
    checks++;
    if (last_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_bubble: got valid=%b, required 0", last_valid);
    end
    drive_cycle(1'b0, 1'b0, 32'h0);
    checks++;
    if (last_valid !== 1'b1 || last_pc !== 32'h40 || last_instr !== 32'h1040) begin
      errors++;
      $display("FAIL flush_target: got v=%b pc=%h instr=%h, required 1/00000040/00001040",
               last_valid, last_pc, last_instr);
    end
    repeat (3) drive_cycle(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_flush_stall();
    apply_reset();
    repeat (2) drive_cycle(1'b0, 1'b0, 32'h0);
    repeat (3) drive_cycle(1'b1, 1'b0, 32'h0);
    checks++;
    if (last_ifstall !== 1'b1) begin
      errors++;
      $display("FAIL flush_stall_full: got if_stall=%b, required 1", last_ifstall);
    end
    drive_cycle(1'b1, 1'b1, 32'h80);
    checks++;
    if (last_ifstall !== 1'b0 || last_en !== 1'b1 || last_addr !== 32'h80) begin
      errors++;
      $display("FAIL flush_stall_issue: got if_stall=%b en=%b addr=%h, required 0/1/00000080",
               last_ifstall, last_en, last_addr);
    end
    drive_cycle(1'b1, 1'b0, 32'h0);
    checks++;
    if (last_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall_bubble: got valid=%b, required 0", last_valid);
    end
    drive_cycle(1'b0, 1'b0, 32'h0);
    checks++;
    if (last_valid !== 1'b1 || last_pc !== 32'h80) begin
      errors++;
      $display("FAIL flush_stall_target: got v=%b pc=%h, required 1/00000080", last_valid, last_pc);
    end
    repeat (3) drive_cycle(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_alternating();
    int start_pops;
    apply_reset();
    repeat (4) drive_cycle(1'b0, 1'b0, 32'h0);
    start_pops = pops;
    for (int i = 0; i < 20; i++) drive_cycle((i % 2) == 0, 1'b0, 32'h0);
    checks++;
    if (pops - start_pops != 10) begin
      errors++;
      $display("FAIL alternating_pops: got %0d, required 10", pops - start_pops);
    end
    repeat (4) drive_cycle(1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    pops       = 0;
    Reset      = 1'b1;
    PC         = 32'h0;
    ID_stall   = 1'b0;
    Flush      = 1'b0;
    imem_rdata = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_flush_stall();
    test_alternating();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
